// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/compare ops, shift-add multiply
// and (with ULA_MULTICICLO_DIV_EN defined) restoring divide, one bit per cycle.
module ula_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] Dados_1,
  input  logic [WIDTH-1:0] Dados_2,
  output logic [WIDTH-1:0] Resultado,
  output logic             Zero,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIM} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, acc_reg;
  logic [5:0]       op_reg, funct_reg;
  logic [CW-1:0]    cnt_reg;
  logic             pend_reg;
  logic             accept, is_mul, is_div, last_iter;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero, alu_dz;

  // Iterative ops are only launched from IDLE; a start seen in the one-cycle FIM slot is dropped.
  assign accept    = start && (state_reg == IDLE);
  assign is_mul    = (Opcode == 6'd0) && (funct == 6'd2);
  assign last_iter = (cnt_reg == CW'(WIDTH - 1));

`ifdef ULA_MULTICICLO_DIV_EN
  logic [WIDTH:0]   rem_shift, rem_sub;
  logic             q_bit;

  // Divide by zero bypasses the iteration and is resolved as a single-cycle op.
  assign is_div    = (Opcode == 6'd0) && (funct == 6'd3) && (Dados_2 != '0);
  assign rem_shift = {acc_reg, a_reg[WIDTH-1]};
  assign rem_sub   = rem_shift - {1'b0, b_reg};
  assign q_bit     = (rem_shift >= {1'b0, b_reg});
`else
  assign is_div    = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && is_mul)      state_next = MUL;
        else if (accept && is_div) state_next = DIV;
      end
      MUL, DIV: if (last_iter) state_next = FIM;
      FIM:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == MUL) || (state_reg == DIV);
  end

  // Single-cycle result, computed from the operands captured at the accepting edge.
  always_comb begin
    alu_res  = '0;
    alu_zero = 1'b0;
    alu_dz   = 1'b0;
    case (op_reg)
      6'd0: begin
        case (funct_reg)
          6'd0: alu_res = a_reg + b_reg;
          6'd1: alu_res = a_reg - b_reg;
          6'd3: begin
`ifdef ULA_MULTICICLO_DIV_EN
            alu_res = '1;
`else
            alu_res = '0;
`endif
            alu_dz  = 1'b1;
          end
          6'd4: alu_res = a_reg + WIDTH'(1);
          6'd5: alu_res = a_reg - WIDTH'(1);
          default: alu_res = '0;
        endcase
      end
      6'd1: begin
        case (funct_reg)
          6'd0: alu_res = a_reg & b_reg;
          6'd1: alu_res = a_reg | b_reg;
          6'd2: alu_res = ~a_reg;
          6'd3: alu_res = a_reg ^ b_reg;
          default: alu_res = '0;
        endcase
      end
      6'd2, 6'd6, 6'd7, 6'd8, 6'd28, 6'd30, 6'd31, 6'd33: alu_res = a_reg + b_reg;
      6'd20:      alu_res = a_reg - b_reg;
      6'd3, 6'd9: alu_res = a_reg;
      6'd4:  alu_res = WIDTH'(a_reg <  b_reg);
      6'd13: alu_res = WIDTH'(a_reg != b_reg);
      6'd15: alu_res = WIDTH'(a_reg >  b_reg);
      6'd16: alu_res = WIDTH'(a_reg == b_reg);
      6'd17: alu_res = WIDTH'(a_reg >= b_reg);
      6'd18: alu_res = WIDTH'(a_reg <= b_reg);
      6'd5: begin
        alu_res  = b_reg;
        alu_zero = 1'b1;
      end
      6'd19: alu_zero = 1'b1;
      6'd10: alu_zero = (a_reg == b_reg);
      6'd11: alu_zero = (a_reg != b_reg);
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      op_reg    <= '0;
      funct_reg <= '0;
      cnt_reg   <= '0;
      pend_reg  <= 1'b0;
      done      <= 1'b0;
      Resultado <= '0;
      Zero      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      if (accept) begin
        a_reg     <= Dados_1;
        b_reg     <= Dados_2;
        op_reg    <= Opcode;
        funct_reg <= funct;
        acc_reg   <= '0;
        cnt_reg   <= '0;
      end else if (state_reg == MUL) begin
        // Multiplicand walks left, multiplier walks right.
        if (b_reg[0]) acc_reg <= acc_reg + a_reg;
        a_reg   <= a_reg << 1;
        b_reg   <= b_reg >> 1;
        cnt_reg <= cnt_reg + CW'(1);
      end
`ifdef ULA_MULTICICLO_DIV_EN
      else if (state_reg == DIV) begin
        // acc_reg holds the partial remainder; a_reg shifts dividend out, quotient in.
        acc_reg <= q_bit ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        a_reg   <= {a_reg[WIDTH-2:0], q_bit};
        cnt_reg <= cnt_reg + CW'(1);
      end
`endif

      pend_reg <= accept && !is_mul && !is_div;
      done     <= pend_reg || (state_reg == FIM);

      if (pend_reg) begin
        Resultado <= alu_res;
        Zero      <= alu_zero;
        div_zero  <= alu_dz;
      end else if (state_reg == FIM) begin
        Resultado <= (funct_reg == 6'd2) ? acc_reg : a_reg;
        Zero      <= 1'b0;
        div_zero  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Self-checking bench for ula_multiciclo: directed vectors plus randomized ops
// checked against an arithmetic reference model.
module tb_ula_multiciclo;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  Opcode = '0, funct = '0;
  logic [31:0] Dados_1 = '0, Dados_2 = '0;
  logic [31:0] Resultado;
  logic        Zero, busy, done, div_zero;

  logic        s8_start = 1'b0;
  logic [5:0]  s8_op = '0, s8_funct = '0;
  logic [7:0]  s8_a = '0, s8_b = '0, s8_res;
  logic        s8_zero, s8_busy, s8_done, s8_dz;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        dz;
    int          lat;
  } exp_t;

  always #5 clock = ~clock;

  ula_multiciclo #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .Opcode(Opcode), .funct(funct),
    .Dados_1(Dados_1), .Dados_2(Dados_2), .Resultado(Resultado), .Zero(Zero),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  ula_multiciclo #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(s8_start), .Opcode(s8_op), .funct(s8_funct),
    .Dados_1(s8_a), .Dados_2(s8_b), .Resultado(s8_res), .Zero(s8_zero),
    .busy(s8_busy), .done(s8_done), .div_zero(s8_dz)
  );

  // Reference: what each operation should produce, and after how many cycles.
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] f,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.r = '0; e.z = 1'b0; e.dz = 1'b0; e.lat = 1;
    case (op)
      6'd0: case (f)
        6'd0: e.r = a + b;
        6'd1: e.r = a - b;
        6'd2: begin e.r = a * b; e.lat = 33; end
        6'd3: begin
`ifdef ULA_MULTICICLO_DIV_EN
          if (b == 0) begin e.r = 32'hFFFF_FFFF; e.dz = 1'b1; end
          else begin e.r = a / b; e.lat = 33; end
`else
          e.dz = 1'b1;
`endif
        end
        6'd4: e.r = a + 1;
        6'd5: e.r = a - 1;
        default: e.r = '0;
      endcase
      6'd1: case (f)
        6'd0: e.r = a & b;
        6'd1: e.r = a | b;
        6'd2: e.r = ~a;
        6'd3: e.r = a ^ b;
        default: e.r = '0;
      endcase
      6'd2, 6'd6, 6'd7, 6'd8, 6'd28, 6'd30, 6'd31, 6'd33: e.r = a + b;
      6'd20: e.r = a - b;
      6'd3, 6'd9: e.r = a;
      6'd4:  e.r = (a <  b) ? 32'd1 : 32'd0;
      6'd13: e.r = (a != b) ? 32'd1 : 32'd0;
      6'd15: e.r = (a >  b) ? 32'd1 : 32'd0;
      6'd16: e.r = (a == b) ? 32'd1 : 32'd0;
      6'd17: e.r = (a >= b) ? 32'd1 : 32'd0;
      6'd18: e.r = (a <= b) ? 32'd1 : 32'd0;
      6'd5:  begin e.r = b; e.z = 1'b1; end
      6'd19: e.z = 1'b1;
      6'd10: e.z = (a == b);
      6'd11: e.z = (a != b);
      default: e.r = '0;
    endcase
    return e;
  endfunction

  // Drive one request from a negedge, scramble inputs after acceptance, and
  // observe latency / busy cycles / outputs at the negedge where done rises.
  task automatic issue(input logic [5:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       output exp_t obs, output int busy_cycles);
    int lat;
    start = 1'b1; Opcode = op; funct = f; Dados_1 = a; Dados_2 = b;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; Opcode = 6'($urandom); funct = 6'($urandom);
    Dados_1 = $urandom; Dados_2 = $urandom;
    lat = 0; busy_cycles = 0;
    while (!done && lat < 100) begin
      busy_cycles += int'(busy);
      @(negedge clock);
      lat++;
    end
    obs.r = Resultado; obs.z = Zero; obs.dz = div_zero; obs.lat = lat;
    $display("txn op=%0d f=%0d a=%h b=%h -> r=%h z=%b dz=%b lat=%0d",
             op, f, a, b, obs.r, obs.z, obs.dz, obs.lat);
  endtask

  task automatic test_reset();
    n_checks++;
    if ({Resultado, Zero, busy, done, div_zero} !== 36'd0 || s8_res !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: got r=%h z=%b busy=%b done=%b dz=%b, want all 0",
               Resultado, Zero, busy, done, div_zero);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_directed();
    exp_t obs, e;
    int bc;
    logic [5:0]  ops [6] = '{6'd0, 6'd0, 6'd10, 6'd11, 6'd5, 6'd0};
    logic [5:0]  fs  [6] = '{6'd0, 6'd2, 6'd0,  6'd0,  6'd0, 6'd3};
    logic [31:0] as  [6] = '{32'hFFFF_FFFF, 32'h1_0000, 32'd5, 32'd5, 32'd9, 32'd100};
    logic [31:0] bs  [6] = '{32'd1, 32'h1_0003, 32'd5, 32'd5, 32'h40, 32'd0};
    exp_t        lit [6];
    lit[0] = '{r: 32'd0,        z: 1'b0, dz: 1'b0, lat: 1};
    lit[1] = '{r: 32'h3_0000,   z: 1'b0, dz: 1'b0, lat: 33};
    lit[2] = '{r: 32'd0,        z: 1'b1, dz: 1'b0, lat: 1};
    lit[3] = '{r: 32'd0,        z: 1'b0, dz: 1'b0, lat: 1};
    lit[4] = '{r: 32'h40,       z: 1'b1, dz: 1'b0, lat: 1};
`ifdef ULA_MULTICICLO_DIV_EN
    lit[5] = '{r: 32'hFFFF_FFFF, z: 1'b0, dz: 1'b1, lat: 1};
`else
    lit[5] = '{r: 32'd0,        z: 1'b0, dz: 1'b1, lat: 1};
`endif
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], fs[i], as[i], bs[i], obs, bc);
      e = lit[i];
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL directed_%0d: got r=%h z=%b dz=%b lat=%0d, want r=%h z=%b dz=%b lat=%0d",
                 i, obs.r, obs.z, obs.dz, obs.lat, e.r, e.z, e.dz, e.lat);
      end
      if (i == 1) begin
        n_checks++;
        if (bc !== 32) begin
          n_fail++;
          $display("FAIL mult_busy_cycles: got %0d, want 32", bc);
        end
      end
    end
`ifdef ULA_MULTICICLO_DIV_EN
    issue(6'd0, 6'd3, 32'd100, 32'd7, obs, bc);
    n_checks++;
    if (obs.r !== 32'd14 || obs.lat !== 33 || obs.dz !== 1'b0) begin
      n_fail++;
      $display("FAIL div_100_7: got r=%0d lat=%0d dz=%b, want r=14 lat=33 dz=0",
               obs.r, obs.lat, obs.dz);
    end
`endif
  endtask

  task automatic test_random_ops();
    exp_t obs, e;
    int bc;
    logic [5:0]  op, f;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      if (i < 12) begin
        op = 6'd0; f = (i % 2 == 0) ? 6'd2 : 6'd3;
      end else begin
        op = 6'($urandom_range(0, 35)); f = 6'($urandom_range(0, 7));
      end
      a = (i % 5 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b = (i % 7 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if (i % 11 == 3) b = '0;
      e = model(op, f, a, b);
      issue(op, f, a, b, obs, bc);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL random_%0d op=%0d f=%0d: got r=%h z=%b dz=%b lat=%0d, want r=%h z=%b dz=%b lat=%0d",
                 i, op, f, obs.r, obs.z, obs.dz, obs.lat, e.r, e.z, e.dz, e.lat);
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] held;
    exp_t obs;
    int bc;
    issue(6'd1, 6'd3, 32'hA5A5_0F0F, 32'hFFFF_0000, obs, bc);
    held = Resultado;
    for (int i = 0; i < 3; i++) begin
      Dados_1 = $urandom; Opcode = 6'($urandom);
      @(negedge clock);
    end
    n_checks++;
    if (Resultado !== 32'h5A5A_0F0F || held !== 32'h5A5A_0F0F || done !== 1'b0) begin
      n_fail++;
      $display("FAIL hold: got r=%h done=%b, want r=5a5a0f0f done=0", Resultado, done);
    end
  endtask

  task automatic test_back_to_back();
    exp_t obs;
    int bc;
    start = 1'b1; Opcode = 6'd0; funct = 6'd0; Dados_1 = 32'd10; Dados_2 = 32'd20;
    @(posedge clock); @(negedge clock);
    Opcode = 6'd20; Dados_1 = 32'd50; Dados_2 = 32'd8;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_latency: got done=%b, want 0", done);
    end
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || Resultado !== 32'd30) begin
      n_fail++;
      $display("FAIL b2b_first: got done=%b r=%0d, want done=1 r=30", done, Resultado);
    end
    @(negedge clock);
    n_checks++;
    if (done !== 1'b1 || Resultado !== 32'd42) begin
      n_fail++;
      $display("FAIL b2b_second: got done=%b r=%0d, want done=1 r=42", done, Resultado);
    end
    // A multiply issued in the very cycle a single-cycle done is high.
    issue(6'd0, 6'd2, 32'd1234, 32'd5678, obs, bc);
    n_checks++;
    if (obs.r !== 32'd7006652 || obs.lat !== 33) begin
      n_fail++;
      $display("FAIL b2b_mult: got r=%0d lat=%0d, want r=7006652 lat=33", obs.r, obs.lat);
    end
  endtask

  task automatic test_busy_and_abort();
    int lat;
    logic extra_done;
    exp_t obs;
    int bc;
    start = 1'b1; Opcode = 6'd0; funct = 6'd2; Dados_1 = 32'd300; Dados_2 = 32'd7;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      start = (lat == 2);
      if (lat == 2) begin Opcode = 6'd0; funct = 6'd0; Dados_1 = 32'd1; Dados_2 = 32'd1; end
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
    n_checks++;
    if (Resultado !== 32'd2100 || lat !== 33) begin
      n_fail++;
      $display("FAIL ignore_start: got r=%0d lat=%0d, want r=2100 lat=33", Resultado, lat);
    end
    extra_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      extra_done |= done;
    end
    n_checks++;
    if (extra_done !== 1'b0) begin
      n_fail++;
      $display("FAIL no_second_done: got done seen=%b, want 0", extra_done);
    end
    start = 1'b1; funct = 6'd2; Dados_1 = 32'hFFFF; Dados_2 = 32'hFFFF;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({Resultado, Zero, busy, done, div_zero} !== 36'd0) begin
      n_fail++;
      $display("FAIL abort_reset: got r=%h z=%b busy=%b done=%b dz=%b, want all 0",
               Resultado, Zero, busy, done, div_zero);
    end
    @(negedge clock);
    reset = 1'b1;
    extra_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      extra_done |= done;
    end
    n_checks++;
    if (extra_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: got done seen=%b, want 0", extra_done);
    end
    issue(6'd0, 6'd4, 32'd41, 32'd0, obs, bc);
    n_checks++;
    if (obs.r !== 32'd42 || obs.lat !== 1) begin
      n_fail++;
      $display("FAIL after_abort: got r=%0d lat=%0d, want r=42 lat=1", obs.r, obs.lat);
    end
  endtask

  task automatic test_width8();
    int lat;
    logic [7:0] a, b, want;
    for (int i = 0; i < 5; i++) begin
      a = (i == 0) ? 8'h10 : 8'($urandom);
      b = (i == 0) ? 8'h10 : 8'($urandom);
      want = 8'((16'(a) * 16'(b)) & 16'hFF);
      s8_start = 1'b1; s8_op = 6'd0; s8_funct = 6'd2; s8_a = a; s8_b = b;
      @(posedge clock); @(negedge clock);
      s8_start = 1'b0; s8_a = 8'($urandom); s8_b = 8'($urandom);
      lat = 0;
      while (!s8_done && lat < 100) begin
        @(negedge clock);
        lat++;
      end
      $display("txn w8 a=%h b=%h -> r=%h lat=%0d", a, b, s8_res, lat);
      n_checks++;
      if (s8_res !== want || lat !== 9) begin
        n_fail++;
        $display("FAIL w8_mult_%0d: got r=%h lat=%0d, want r=%h lat=9", i, s8_res, lat, want);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_directed();
    test_random_ops();
    test_hold();
    test_back_to_back();
    test_busy_and_abort();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_multiciclo.md
ULA_MULTICICLO -- requirements
Module: ula_multiciclo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width (legal 8..64).
REQ-002 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request; sampled only when busy=0.
REQ-005 SHALL have port Opcode  input  6  operation class.
REQ-006 SHALL have port funct  input  6  sub-operation for Opcode 0 and 1.
REQ-007 SHALL have ports Dados_1, Dados_2  input  WIDTH  operands, unsigned.
REQ-008 SHALL have port Resultado  output  WIDTH  registered result.
REQ-009 SHALL have port Zero  output  1  registered branch/jump-taken flag.
REQ-010 SHALL have port busy  output  1  high while an iterative operation runs.
REQ-011 SHALL have port done  output  1  one-cycle pulse when Resultado/Zero are valid.
REQ-012 SHALL have port div_zero  output  1  registered divide-by-zero flag.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, FIM; IDLE->MUL on start with Opcode 0/funct 2; IDLE->DIV on start with Opcode 0/funct 3; MUL/DIV->FIM after WIDTH iterations; FIM->IDLE unconditionally.
REQ-014 SHALL capture Dados_1, Dados_2, Opcode, funct at the accepting edge; later input changes SHALL NOT affect the operation.
REQ-015 Single-cycle ops: start accepted at edge k SHALL give done=1 and valid outputs after edge k+1 (1-cycle latency, FSM stays IDLE).
REQ-016 MULT: shift-add, one bit per cycle; done SHALL pulse after edge k+WIDTH+1; Resultado = low WIDTH bits of product.
REQ-017 DIV: restoring division, one quotient bit per cycle; same latency as MULT; Resultado = quotient.
REQ-018 DIV with Dados_2=0 SHALL skip iteration: Resultado = all ones, div_zero=1, done after 1 cycle.
REQ-019 Opcode 0: funct 0 add, 1 sub, 4 Dados_1+1, 5 Dados_1-1 (all modulo 2^WIDTH); other funct -> 0.
REQ-020 Opcode 1: funct 0 AND, 1 OR, 2 NOT Dados_1, 3 XOR; other funct -> 0.
REQ-021 Opcodes 2,6,7,8,28,30,31,33 -> Dados_1+Dados_2; 20 -> Dados_1-Dados_2; 3,9 -> Dados_1.
REQ-022 Opcodes 4,13,15,16,17,18 -> zero-extended 1-bit compare <, !=, >, ==, >=, <= respectively.
REQ-023 Opcode 5 -> Resultado=Dados_2, Zero=1; 19 -> Resultado=0, Zero=1; 10 -> Zero=(Dados_1==Dados_2); 11 -> Zero=(Dados_1!=Dados_2), Resultado=0 for both.
REQ-024 Zero SHALL be 0 for every opcode not in REQ-023; unlisted opcodes SHALL yield Resultado=0.
REQ-025 start while busy=1 SHALL be ignored; no queueing.
REQ-026 Resultado, Zero, div_zero SHALL hold their values until the next done; done SHALL never be high two consecutive cycles except back-to-back single-cycle ops.
REQ-027 start asserted in the cycle done=1 SHALL be accepted (back-to-back).

Reset
REQ-028 reset=0 SHALL immediately force state IDLE, Resultado=0, Zero=0, busy=0, done=0, div_zero=0, iteration counter=0.
REQ-029 reset mid MUL/DIV SHALL abort with no done pulse; first start after release SHALL be accepted normally.

Configuration
REQ-030 Macro ULA_MULTICICLO_DIV_EN defined: divider per REQ-017/018 SHALL be compiled in.
REQ-031 Macro absent: no divider logic; Opcode 0/funct 3 SHALL complete in 1 cycle with Resultado=0, div_zero=1, state DIV unreachable.

Verification
REQ-032 WIDTH=32, Opcode 0 funct 0, 0xFFFFFFFF+1, start -> done next cycle, Resultado=0, Zero=0.
REQ-033 Opcode 0 funct 2, 0x10000*0x10003 -> busy 32 cycles, done at k+33, Resultado=0x00030000.
REQ-034 Opcode 0 funct 3, 100/7 (DIV_EN) -> Resultado=14 at k+33; 100/0 -> Resultado=0xFFFFFFFF, div_zero=1 at k+1.
REQ-035 Opcode 10, 5,5 -> Zero=1; Opcode 11, 5,5 -> Zero=0; Opcode 5, Dados_2=0x40 -> Resultado=0x40, Zero=1.
REQ-036 Start MULT, re-pulse start at cycle 3 with Opcode 0 funct 0 -> ignored, only MULT done; then reset=0 at cycle 10 of new MULT -> all outputs 0, no done.
REQ-037 WIDTH=8: Opcode 0 funct 2, 0x10*0x10 -> done at k+9, Resultado=0x00.
